// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT job scheduler.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int NTT_LEVELS  = 6;
  localparam int NTT_SLOTS   = 32;
  localparam int PASS_CYCLES = NTT_LEVELS * NTT_SLOTS;
  localparam int DRAIN_NTT   = 7;
  localparam int DRAIN_INTT  = 8;
  localparam int BIAS_W      = 11;
  localparam int NPOLY_W     = 4;
  localparam int TIMER_W     = 8;
  localparam int PERF_W      = 16;

  localparam logic [BIAS_W-1:0] POLY_STRIDE = 11'd32;

  // The timer raises terminal count on its final cycle, so it is loaded with length-1.
  function automatic logic [TIMER_W-1:0] timer_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ntt_job_scheduler_if.sv
// Job command and sequencing-control bundle; perf_cycles exists only with NTT_JOB_SCHED_PERF_EN.
interface ntt_job_scheduler_if;
  import ntt_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_intt;
  logic [NPOLY_W-1:0]    cmd_npoly;
  logic [BIAS_W-1:0]     cmd_bias;
  logic                  abort;
  logic                  server_counter_start;
  logic                  ntt_start;
  logic                  intt_start;
  logic                  mode_intt;
  logic [BIAS_W-1:0]     addr_bias;
  logic [NPOLY_W-1:0]    poly_idx;
  logic                  busy;
  logic                  done;
`ifdef NTT_JOB_SCHED_PERF_EN
  logic [PERF_W-1:0]     perf_cycles;
`endif

  modport master (
    output cmd_valid, cmd_intt, cmd_npoly, cmd_bias, abort,
    input  cmd_ready, server_counter_start, ntt_start, intt_start,
    input  mode_intt, addr_bias, poly_idx, busy, done
`ifdef NTT_JOB_SCHED_PERF_EN
    , input perf_cycles
`endif
  );

  modport slave (
    input  cmd_valid, cmd_intt, cmd_npoly, cmd_bias, abort,
    output cmd_ready, server_counter_start, ntt_start, intt_start,
    output mode_intt, addr_bias, poly_idx, busy, done
`ifdef NTT_JOB_SCHED_PERF_EN
    , output perf_cycles
`endif
  );

endinterface

// File: rtl/ntt_job_timer.sv
// Loadable down-counter timing both the transform pass and the drain gap.
module ntt_job_timer
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               tc
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == '0);

endmodule

// File: rtl/ntt_job_scheduler.sv
// Batch sequencer for NTT/INTT passes over back-to-back polynomials.
// Optional cycle counter output enabled by NTT_JOB_SCHED_PERF_EN.
module ntt_job_scheduler
  import ntt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ntt_job_scheduler_if.slave job
);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [NPOLY_W-1:0] npoly_q, npoly_d;
  logic [NPOLY_W-1:0] idx_q, idx_d;
  logic [BIAS_W-1:0]  bias_q, bias_d;

  logic               tmr_en;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_tc;
  logic               accept;

  assign accept = (state_q == IDLE) && job.cmd_valid;
  assign tmr_en = (state_q == RUN) || (state_q == DRAIN);

  ntt_job_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (tmr_en),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tc         (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    npoly_d   = npoly_q;
    idx_d     = idx_q;
    bias_d    = bias_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = RUN;
          mode_d    = job.cmd_intt;
          npoly_d   = job.cmd_npoly;
          bias_d    = job.cmd_bias;
          idx_d     = '0;
          tmr_load  = 1'b1;
          tmr_value = timer_load(PASS_CYCLES);
        end
      end
      RUN: begin
        if (tmr_tc) begin
          state_d   = DRAIN;
          tmr_load  = 1'b1;
          tmr_value = mode_q ? timer_load(DRAIN_INTT) : timer_load(DRAIN_NTT);
        end
      end
      DRAIN: begin
        // npoly of 0 wraps npoly-1 to 15, giving the 16-polynomial batch.
        if (tmr_tc) begin
          if (idx_q == (npoly_q - 1'b1)) begin
            state_d = DONE;
          end else begin
            state_d   = RUN;
            idx_d     = idx_q + 1'b1;
            bias_d    = bias_q + POLY_STRIDE;
            tmr_load  = 1'b1;
            tmr_value = timer_load(PASS_CYCLES);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (job.abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      idx_d     = idx_q;
      bias_d    = bias_q;
      tmr_load  = 1'b1;
      tmr_value = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      npoly_q <= '0;
      idx_q   <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      npoly_q <= npoly_d;
      idx_q   <= idx_d;
      bias_q  <= bias_d;
    end
  end

  assign job.cmd_ready            = (state_q == IDLE);
  assign job.busy                 = (state_q != IDLE);
  assign job.server_counter_start = (state_q != IDLE);
  assign job.ntt_start            = (state_q == RUN) && !mode_q;
  assign job.intt_start           = (state_q == RUN) && mode_q;
  assign job.done                 = (state_q == DONE);
  assign job.mode_intt            = mode_q;
  assign job.addr_bias            = bias_q;
  assign job.poly_idx             = idx_q;

`ifdef NTT_JOB_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept) begin
      perf_d = '0;
    end else if ((state_q != IDLE) && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign job.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Scoreboard bench for ntt_job_scheduler: expected passes and done cycles are queued at submit time.
module tb_ntt_job_scheduler;

  typedef struct {
    logic [10:0] bias;
    logic [3:0]  idx;
    logic        intt;
    int          cyc;
  } pass_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ntt_job_scheduler_if bus ();

  ntt_job_scheduler dut (
    .clk (clk),
    .rst (rst),
    .job (bus)
  );

  always #5 clk = ~clk;

  pass_t pass_q[$];
  int    done_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    run_len = 0;
  int    exp_done = 0;
  logic  st_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: cycle numbering restarts at every accept edge (accept edge = cycle 0).
  always @(negedge clk) begin
    logic st;
    pass_t e;
    cyc++;
    st = bus.ntt_start | bus.intt_start;
    if (st && !st_prev) begin
      if (pass_q.size() == 0) begin
        chk("pass_unexpected", 1, 0);
      end else begin
        e = pass_q.pop_front();
        $display("[TB] pass idx=%0d bias=0x%03h intt=%0b at cycle %0d", bus.poly_idx, bus.addr_bias, bus.mode_intt, cyc);
        chk("pass_cycle", cyc, e.cyc);
        chk("addr_bias", bus.addr_bias, e.bias);
        chk("poly_idx", bus.poly_idx, e.idx);
        chk("mode_intt", bus.mode_intt, e.intt);
        chk("ntt_start", bus.ntt_start, !e.intt);
        chk("intt_start", bus.intt_start, e.intt);
        chk("ready_in_run", bus.cmd_ready, 0);
        chk("counter_start", bus.server_counter_start, 1);
      end
      run_len = 0;
    end
    if (st) run_len++;
    if (!st && st_prev && bus.busy) begin
      chk("pass_len", run_len, 192);
      chk("counter_in_drain", bus.server_counter_start, 1);
    end
    if (bus.done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        $display("[TB] done at cycle %0d", cyc);
        chk("done_cycle", cyc, done_q.pop_front());
        chk("done_busy", bus.busy, 1);
        chk("done_starts", st, 0);
      end
    end
    st_prev = st;
    if (bus.cmd_valid && bus.cmd_ready) cyc = 0;
  end

  task automatic submit(input logic intt, input logic [3:0] np, input logic [10:0] bias,
                        input logic with_abort, input logic hold);
    int n;
    int d;
    pass_t e;
    n = (np == 4'd0) ? 16 : int'(np);
    d = intt ? 8 : 7;
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      e.bias = bias + 11'(k * 32);
      e.idx  = 4'(k);
      e.intt = intt;
      e.cyc  = 1 + k * (192 + d);
      pass_q.push_back(e);
    end
    exp_done = n * (192 + d) + 1;
    done_q.push_back(exp_done);
    bus.cmd_intt  = intt;
    bus.cmd_npoly = np;
    bus.cmd_bias  = bias;
    bus.abort     = with_abort;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("ready_after_done", bus.cmd_ready, 1);
    chk("idle_after_done", bus.busy, 0);
    chk("passes_left", pass_q.size(), 0);
`ifdef NTT_JOB_SCHED_PERF_EN
    chk("perf_cycles", bus.perf_cycles, exp_done);
`endif
  endtask

  task automatic wait_cycle(input int target, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cyc == target) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("cycle_timeout", 0, 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_intt  = 1'b0;
    bus.cmd_npoly = 4'd0;
    bus.cmd_bias  = 11'd0;
    bus.abort     = 1'b0;
    #3;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_counter", bus.server_counter_start, 0);
    chk("rst_bias", bus.addr_bias, 0);
    chk("rst_idx", bus.poly_idx, 0);
    chk("rst_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single NTT
    submit(1'b0, 4'd1, 11'h000, 1'b0, 1'b0);
    wait_done(400);
    // INTT batch of three
    submit(1'b1, 4'd3, 11'h100, 1'b0, 1'b0);
    wait_done(800);
    // bias wrap
    submit(1'b0, 4'd2, 11'h7F0, 1'b0, 1'b0);
    wait_done(600);
    // npoly = 0 means 16
    submit(1'b0, 4'd0, 11'h000, 1'b0, 1'b0);
    wait_done(3500);
    chk("last_idx", bus.poly_idx, 15);

    // abort at cycle 100 of the second pass
    submit(1'b0, 4'd3, 11'h200, 1'b0, 1'b0);
    wait_cycle(300, 400);
    bus.abort = 1'b1;
    pass_q.delete();
    done_q.delete();
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_ntt", bus.ntt_start, 0);
    chk("abort_counter", bus.server_counter_start, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    // accept alongside an abort in IDLE
    submit(1'b1, 4'd1, 11'h055, 1'b1, 1'b0);
    wait_done(400);

    // asynchronous reset in the middle of DRAIN
    submit(1'b0, 4'd1, 11'h3A0, 1'b0, 1'b0);
    wait_cycle(195, 300);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.cmd_ready, 1);
    chk("arst_counter", bus.server_counter_start, 0);
    chk("arst_bias", bus.addr_bias, 0);
    chk("arst_mode", bus.mode_intt, 0);
    pass_q.delete();
    done_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("arst_no_job", bus.busy, 0);

    // cmd_valid held through the job must not be re-accepted before done
    submit(1'b1, 4'd2, 11'h010, 1'b0, 1'b1);
    wait_done(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_job_scheduler.md
Name: ntt_job_scheduler

Overview:
- Sequences the NTT/INTT address counter and butterfly pipeline over a batch of polynomials stored back-to-back in coefficient RAM.
- Accepts one job per valid/ready handshake: mode, polynomial count and base address.
- Per polynomial, drives the counter-enable/start controls for exactly one full 6-level pass.
- Holds the starts low for a pipeline-drain gap, advances addr_bias, and pulses done after the last polynomial.

Parameters:
- POLY_STRIDE, 32: addr_bias increment per polynomial (RAM words per polynomial).
- PASS_CYCLES, 192: cycles per transform (6 levels x 32 butterfly slots).
- DRAIN_NTT, 7: gap cycles after an NTT pass (write lag).
- DRAIN_INTT, 8: gap cycles after an INTT pass (write lag, one extra stage).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE; a job is accepted on an edge where cmd_valid & cmd_ready.
- cmd_intt  in  1  0 = forward NTT, 1 = inverse NTT.
- cmd_npoly  in  4  polynomial count; 0 encodes 16.
- cmd_bias  in  11  address bias of the first polynomial.
- abort  in  1  synchronous job cancel.
- server_counter_start  out  1  counter enable; high for the whole job (RUN, DRAIN and DONE).
- ntt_start  out  1  forward pass enable.
- intt_start  out  1  inverse pass enable.
- mode_intt  out  1  latched cmd_intt; stable for the whole job.
- addr_bias  out  11  bias of the current polynomial.
- poly_idx  out  4  index of the current polynomial.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset: state = IDLE.
  - All outputs 0, except cmd_ready = 1.
  - addr_bias, poly_idx and all internal counters = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On accept, latch mode, npoly and bias; poly_idx = 0; addr_bias = cmd_bias; go to RUN.
  - cmd_valid while busy is ignored; nothing is queued.
- RUN: server_counter_start = 1.
  - ntt_start = ~mode_intt and intt_start = mode_intt; never both high.
  - A pass counter counts 0..PASS_CYCLES-1, so the start is high exactly 192 consecutive cycles.
  - After the last count, go to DRAIN.
- DRAIN: both starts = 0, which returns the downstream counter to 0.
  - Lasts DRAIN_NTT or DRAIN_INTT cycles, selected by mode_intt.
  - At the end, if poly_idx == npoly-1 (16 when npoly = 0), go to DONE.
  - Otherwise: poly_idx += 1, addr_bias += POLY_STRIDE, go to RUN.
- DONE: one cycle with done = 1 and busy = 1, then IDLE; cmd_ready returns to 1 the following cycle.
- Address arithmetic: addr_bias is computed modulo 2^11 and wraps silently.
- Timing for one polynomial, with the accept edge at cycle 0:
  - NTT: starts high in cycles 1..192, drain 193..199, done at cycle 200.
  - INTT: done at cycle 201.
- abort (any non-IDLE state): next cycle is IDLE; server_counter_start, both starts and busy = 0; no done pulse.
  - abort has priority over every other transition.
  - abort in IDLE has no effect; simultaneous abort and cmd_valid in IDLE accepts the job.
- rst mid-job: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro NTT_JOB_SCHED_PERF_EN.
  - Defined: adds output perf_cycles (16 bits). It clears on accept, increments every busy cycle and saturates at 0xFFFF. It holds its value in IDLE and resets to 0 on rst.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package ntt_pkg:
  - state enum: IDLE, RUN, DRAIN, DONE;
  - constants NTT_LEVELS = 6, NTT_SLOTS = 32, PASS_CYCLES = 192, DRAIN_NTT = 7, DRAIN_INTT = 8, BIAS_W = 11.
- Sub-module ntt_job_timer: a loadable down-counter shared by RUN and DRAIN.
  - Inputs: load, load_value.
  - Output: a terminal-count pulse.

Test Plan:
- NTT, npoly = 1, bias = 0x000: ntt_start high exactly 192 cycles; intt_start stays 0; 7-cycle gap; done at cycle 200; cmd_ready = 1 at cycle 201.
- INTT, npoly = 3, bias = 0x100: addr_bias = 0x100, 0x120, 0x140 in successive passes; 8-cycle gaps; mode_intt = 1 throughout; done once, at cycle 3*(192+8)+1 = 601.
- npoly = 2, bias = 0x7F0: second pass addr_bias = 0x010 (wrap); npoly = 0 yields 16 passes, poly_idx ending at 15.
- abort at cycle 100 of pass 2: next cycle all starts and busy = 0, no done; a new job accepted immediately afterwards starts at poly_idx = 0.
- rst asserted mid-DRAIN: outputs take reset values asynchronously, with no clock edge needed; cmd_valid held high during a job is not accepted until after done.
